// File: rtl/tracer_pkg.sv
// Shared parameters, state type and lane helpers for the trace-buffer capture front end.
package tracer_pkg;

  localparam int TRB_WIDTH       = 32;
  localparam int TRB_MAX_TRACES  = 8;
  localparam int TRB_NTRACE_BITS = 2;

  localparam int POS_W    = $clog2(TRB_WIDTH);
  localparam int LOG2_MAX = $clog2(TRB_MAX_TRACES);
  localparam int CNT_W    = POS_W + 1;

  typedef enum logic [1:0] {
    CAPTURE,
    DONE,
    STREAM
  } tracer_state_t;

  // Lane-count exponent, clamped so n never exceeds the physical lane count.
  function automatic logic [TRB_NTRACE_BITS-1:0] clamp_log2n(
    input logic [TRB_NTRACE_BITS-1:0] ntrace
  );
    if (int'(ntrace) > LOG2_MAX) return TRB_NTRACE_BITS'(LOG2_MAX);
    return ntrace;
  endfunction

  function automatic int lane_count(input logic [TRB_NTRACE_BITS-1:0] log2n);
    return 1 << log2n;
  endfunction

  function automatic logic [TRB_MAX_TRACES-1:0] lane_mask(
    input logic [TRB_NTRACE_BITS-1:0] log2n
  );
    return ~({TRB_MAX_TRACES{1'b1}} << lane_count(log2n));
  endfunction

endpackage

// File: rtl/tracer_if.sv
// Logger-facing bus of the tracer: capture inputs, store/stream outputs and the load handshake.
interface tracer_if;
  import tracer_pkg::*;

  logic                       mode_i;
  logic [TRB_NTRACE_BITS-1:0] ntrace_i;
  logic [TRB_MAX_TRACES-1:0]  trace_i;
  logic [TRB_MAX_TRACES-1:0]  trg_i;
  logic                       trg_delayed_i;
  logic                       store_perm_i;
  logic                       store_o;
  logic [TRB_WIDTH-1:0]       data_o;
  logic                       trg_event_o;
  logic [POS_W-1:0]           event_pos_o;
  logic                       overflow_o;
  logic                       load_request_o;
  logic                       load_grant_i;
  logic [TRB_WIDTH-1:0]       data_i;
  logic [TRB_MAX_TRACES-1:0]  stream_o;
  logic                       stream_valid_o;

  modport master (
    input  mode_i, ntrace_i, trace_i, trg_i, trg_delayed_i, store_perm_i,
           load_grant_i, data_i,
    output store_o, data_o, trg_event_o, event_pos_o, overflow_o,
           load_request_o, stream_o, stream_valid_o
  );

  modport slave (
    output mode_i, ntrace_i, trace_i, trg_i, trg_delayed_i, store_perm_i,
           load_grant_i, data_i,
    input  store_o, data_o, trg_event_o, event_pos_o, overflow_o,
           load_request_o, stream_o, stream_valid_o
  );

endinterface

// File: rtl/trace_packer.sv
// Lane packer: writes the active lanes at bit offset pos, advances pos by n and flags the
// beat that fills the last bits of the word.
module trace_packer
  import tracer_pkg::*;
(
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       en,
  input  logic [TRB_NTRACE_BITS-1:0] log2n,
  input  logic [TRB_MAX_TRACES-1:0]  lanes,
  output logic [POS_W-1:0]           pos_o,
  output logic                       complete_o,
  output logic [TRB_WIDTH-1:0]       word_o
);

  logic [POS_W-1:0]     pos_q, pos_d;
  logic [TRB_WIDTH-1:0] pack_q, pack_d;
  logic [POS_W:0]       pos_next;
  logic [TRB_WIDTH-1:0] beat_mask;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    beat_mask  = TRB_WIDTH'(lane_mask(log2n)) << pos_q;
    word_o     = (pack_q & ~beat_mask) | (TRB_WIDTH'(lanes) << pos_q);
    pos_next   = {1'b0, pos_q} + (POS_W+1)'(lane_count(log2n));
    complete_o = en && (pos_next == (POS_W+1)'(TRB_WIDTH));
    pos_d      = pos_q;
    pack_d     = pack_q;
    if (clear) begin
      pos_d  = '0;
      // NOTE: the pack register is cleared only to keep simulation deterministic; every bit
      // is rewritten before a word completes, so its content never leaks into a store.
      pack_d = '0;
    end else if (en) begin
      pos_d  = pos_next[POS_W-1:0];
      pack_d = word_o;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    pos_q  <= pos_d;
    pack_q <= pack_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/tracer.sv
// Trace-buffer front end: packs trace lanes into words for the logger in capture mode and
// unpacks logger words back onto the lanes in streaming mode.
module tracer
  import tracer_pkg::*;
(
  input  logic     CLK_I,
  input  logic     RST_I,
  tracer_if.master bus
);

  tracer_state_t              state_q, state_d;
  logic                       mode_q;
  logic [TRB_NTRACE_BITS-1:0] ntrace_q;

  logic                       store_q, store_d;
  logic [TRB_WIDTH-1:0]       data_q, data_d;
  logic                       trg_event_q, trg_event_d;
  logic                       trg_seen_q, trg_seen_d;
  logic [POS_W-1:0]           event_pos_q, event_pos_d;
  logic                       overflow_q, overflow_d;

  logic                       req_q, req_d;
  logic                       need_req_q, need_req_d;
  logic                       waiting_q, waiting_d;
  logic [TRB_WIDTH-1:0]       unpack_q, unpack_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TRB_MAX_TRACES-1:0]  stream_q, stream_d;
  logic                       valid_q, valid_d;

  logic                       clear;
  logic [TRB_NTRACE_BITS-1:0] log2n;
  logic [TRB_MAX_TRACES-1:0]  lmask;
  logic [CNT_W-1:0]           beats;
  logic                       trg_hit;
  logic [POS_W-1:0]           pos;
  logic                       complete;
  logic [TRB_WIDTH-1:0]       word;

  // A configuration change acts exactly like a reset cycle.
  assign clear   = RST_I || (bus.mode_i != mode_q) || (bus.ntrace_i != ntrace_q);
  assign log2n   = clamp_log2n(bus.ntrace_i);
  assign lmask   = lane_mask(log2n);
  assign beats   = CNT_W'(TRB_WIDTH >> log2n);
  assign trg_hit = |(bus.trg_i & lmask);

  trace_packer u_packer (
    .clk        (CLK_I),
    .clear      (clear),
    .en         (state_q == CAPTURE),
    .log2n      (log2n),
    .lanes      (bus.trace_i & lmask),
    .pos_o      (pos),
    .complete_o (complete),
    .word_o     (word)
  );

  always_comb begin
    state_d     = state_q;
    store_d     = 1'b0;
    data_d      = data_q;
    trg_event_d = trg_event_q;
    trg_seen_d  = trg_seen_q;
    event_pos_d = event_pos_q;
    overflow_d  = overflow_q;
    req_d       = 1'b0;
    need_req_d  = need_req_q;
    waiting_d   = waiting_q;
    unpack_d    = unpack_q;
    cnt_d       = cnt_q;
    stream_d    = '0;
    valid_d     = 1'b0;

    if (clear) begin
      state_d     = bus.mode_i ? STREAM : CAPTURE;
      data_d      = '0;
      trg_event_d = 1'b0;
      trg_seen_d  = 1'b0;
      event_pos_d = '0;
      overflow_d  = 1'b0;
      need_req_d  = bus.mode_i;
      waiting_d   = 1'b0;
      unpack_d    = '0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (trg_hit && !trg_seen_q) begin
            trg_seen_d  = 1'b1;
            event_pos_d = pos;
          end
          if (complete) begin
            if (bus.store_perm_i) begin
              store_d = 1'b1;
              data_d  = word;
            end else begin
              overflow_d = 1'b1;
            end
            // The trigger flag follows the word that holds the trigger beat, stored or not.
            if (trg_seen_q || trg_hit) trg_event_d = 1'b1;
          end
          if (bus.trg_delayed_i) state_d = DONE;
        end

        DONE: ;

        STREAM: begin
          if (cnt_q != '0) begin
            stream_d = unpack_q[TRB_MAX_TRACES-1:0] & lmask;
            valid_d  = 1'b1;
            unpack_d = unpack_q >> lane_count(log2n);
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              req_d     = 1'b1;
              waiting_d = 1'b1;
            end
          end else if (waiting_q && bus.load_grant_i) begin
            stream_d  = bus.data_i[TRB_MAX_TRACES-1:0] & lmask;
            valid_d   = 1'b1;
            unpack_d  = bus.data_i >> lane_count(log2n);
            cnt_d     = beats - CNT_W'(1);
            waiting_d = 1'b0;
            if (beats == CNT_W'(1)) begin
              req_d     = 1'b1;
              waiting_d = 1'b1;
            end
          end else if (need_req_q) begin
            req_d      = 1'b1;
            waiting_d  = 1'b1;
            need_req_d = 1'b0;
          end
        end

        default: state_d = CAPTURE;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    state_q     <= state_d;
    mode_q      <= bus.mode_i;
    ntrace_q    <= bus.ntrace_i;
    store_q     <= store_d;
    data_q      <= data_d;
    trg_event_q <= trg_event_d;
    trg_seen_q  <= trg_seen_d;
    event_pos_q <= event_pos_d;
    overflow_q  <= overflow_d;
    req_q       <= req_d;
    need_req_q  <= need_req_d;
    waiting_q   <= waiting_d;
    unpack_q    <= unpack_d;
    cnt_q       <= cnt_d;
    stream_q    <= stream_d;
    valid_q     <= valid_d;
  end

  assign bus.store_o        = store_q;
  assign bus.data_o         = data_q;
  assign bus.trg_event_o    = trg_event_q;
  assign bus.event_pos_o    = event_pos_q;
  assign bus.overflow_o     = overflow_q;
  assign bus.load_request_o = req_q;
  assign bus.stream_o       = stream_q;
  assign bus.stream_valid_o = valid_q;

endmodule

// File: tb/tb_tracer.sv
// Directed bench for tracer: expected stores and stream beats are queued as stimulus is
// issued and checked by an independent monitor whenever the design presents them.
module tb_tracer;
  import tracer_pkg::*;

  logic clk = 1'b0;
  logic rst;

  tracer_if bus ();

  tracer u_dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TRB_WIDTH-1:0] data;
    logic                 trg_event;
  } store_exp_t;

  typedef struct {
    logic [TRB_MAX_TRACES-1:0] lanes;
    logic                      req;
  } stream_exp_t;

  store_exp_t  store_q[$];
  stream_exp_t stream_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented store / stream beat against the queued expectation.
  always @(negedge clk) begin
    store_exp_t  se;
    stream_exp_t te;
    if (bus.store_o === 1'b1) begin
      if (store_q.size() == 0) check("unexpected_store", 32'd1, 32'd0);
      else begin
        se = store_q.pop_front();
        check("store_data", bus.data_o, se.data);
        check("store_trg_event", 32'(bus.trg_event_o), 32'(se.trg_event));
      end
    end
    if (bus.stream_valid_o === 1'b1) begin
      if (stream_q.size() == 0) check("unexpected_stream", 32'd1, 32'd0);
      else begin
        te = stream_q.pop_front();
        check("stream_lanes", 32'(bus.stream_o), 32'(te.lanes));
        check("stream_request", 32'(bus.load_request_o), 32'(te.req));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] tr, input logic [7:0] tg, input logic perm,
                      input logic dly);
    bus.trace_i       = tr;
    bus.trg_i         = tg;
    bus.store_perm_i  = perm;
    bus.trg_delayed_i = dly;
    tick();
  endtask

  task automatic do_reset(input logic mode, input logic [TRB_NTRACE_BITS-1:0] ntr);
    rst               = 1'b1;
    bus.mode_i        = mode;
    bus.ntrace_i      = ntr;
    bus.trace_i       = '0;
    bus.trg_i         = '0;
    bus.trg_delayed_i = 1'b0;
    bus.store_perm_i  = 1'b1;
    bus.load_grant_i  = 1'b0;
    bus.data_i        = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [TRB_WIDTH-1:0] w;

    // Reset state and test 1: n=8 basic pack and store latency
    do_reset(1'b0, 2'd3);
    @(negedge clk);
    check("rst_store", 32'(bus.store_o), 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_trg_event", 32'(bus.trg_event_o), 32'd0);
    check("rst_event_pos", 32'(bus.event_pos_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_load_req", 32'(bus.load_request_o), 32'd0);
    check("rst_stream_valid", 32'(bus.stream_valid_o), 32'd0);
    check("rst_stream", 32'(bus.stream_o), 32'd0);

    store_q.push_back('{32'h0403_0201, 1'b0});
    beat(8'h01, 8'h00, 1'b1, 1'b0);
    beat(8'h02, 8'h00, 1'b1, 1'b0);
    beat(8'h03, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_no_early_store", 32'(bus.store_o), 32'd0);
    beat(8'h04, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_store_latency", 32'(bus.store_o), 32'd1);

    // Test 2: n=1, trigger on beat 7, inactive lanes driven high to prove masking
    do_reset(1'b0, 2'd0);
    w = 32'hA5C3_0F96;
    store_q.push_back('{w, 1'b1});
    for (int k = 0; k < 32; k++) begin
      beat({7'h7F, w[k]}, {7'h7F, (k == 7)}, 1'b1, 1'b0);
      if (k == 20) begin
        @(negedge clk);
        check("t2_trg_event_pending", 32'(bus.trg_event_o), 32'd0);
        check("t2_event_pos", 32'(bus.event_pos_o), 32'd7);
      end
    end
    for (int k = 0; k < 3; k++) begin
      beat(8'hFE, 8'h01, 1'b1, 1'b0);
      @(negedge clk);
      check("t2_trg_event_sticky", 32'(bus.trg_event_o), 32'd1);
    end
    check("t2_later_trigger_ignored", 32'(bus.event_pos_o), 32'd7);

    // Test 3: dropped word sets overflow; next word stores; trigger on completing beat
    do_reset(1'b0, 2'd3);
    beat(8'h11, 8'h00, 1'b1, 1'b0);
    beat(8'h22, 8'h00, 1'b1, 1'b0);
    beat(8'h33, 8'h00, 1'b1, 1'b0);
    beat(8'h44, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_no_store_on_drop", 32'(bus.store_o), 32'd0);
    check("t3_overflow_set", 32'(bus.overflow_o), 32'd1);
    check("t3_no_trg_event", 32'(bus.trg_event_o), 32'd0);
    store_q.push_back('{32'h8877_6655, 1'b1});
    beat(8'h55, 8'h00, 1'b1, 1'b0);
    beat(8'h66, 8'h00, 1'b1, 1'b0);
    beat(8'h77, 8'h00, 1'b1, 1'b0);
    beat(8'h88, 8'h10, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_store_after_drop", 32'(bus.store_o), 32'd1);
    check("t3_event_pos", 32'(bus.event_pos_o), 32'd24);
    check("t3_overflow_sticky", 32'(bus.overflow_o), 32'd1);

    // Test 4: delayed trigger on a completing beat still stores, then nothing more
    store_q.push_back('{32'h0403_0201, 1'b1});
    beat(8'h01, 8'h00, 1'b1, 1'b0);
    beat(8'h02, 8'h00, 1'b1, 1'b0);
    beat(8'h03, 8'h00, 1'b1, 1'b0);
    beat(8'h04, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_store_with_delayed", 32'(bus.store_o), 32'd1);
    for (int k = 0; k < 100; k++) beat(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    @(negedge clk);
    check("t4_overflow_hold", 32'(bus.overflow_o), 32'd1);
    check("t4_trg_event_hold", 32'(bus.trg_event_o), 32'd1);
    check("t4_event_pos_hold", 32'(bus.event_pos_o), 32'd24);
    check("t4_data_hold", bus.data_o, 32'h0403_0201);

    // Test 5: streaming n=8
    do_reset(1'b1, 2'd3);
    beat(8'h00, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_first_request", 32'(bus.load_request_o), 32'd1);
    check("t5_idle_valid", 32'(bus.stream_valid_o), 32'd0);
    beat(8'h00, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_request_pulse", 32'(bus.load_request_o), 32'd0);
    check("t5_waiting_valid", 32'(bus.stream_valid_o), 32'd0);
    stream_q.push_back('{8'hAA, 1'b0});
    stream_q.push_back('{8'hBB, 1'b0});
    stream_q.push_back('{8'hCC, 1'b0});
    stream_q.push_back('{8'hDD, 1'b1});
    bus.load_grant_i = 1'b1;
    bus.data_i       = 32'hDDCC_BBAA;
    tick();
    bus.data_i       = 32'h1234_5678;
    @(negedge clk);
    check("t5_stream_latency", 32'(bus.stream_valid_o), 32'd1);
    tick();
    bus.load_grant_i = 1'b0;
    tick();
    tick();
    stream_q.push_back('{8'h11, 1'b0});
    stream_q.push_back('{8'h22, 1'b0});
    stream_q.push_back('{8'h33, 1'b0});
    stream_q.push_back('{8'h44, 1'b1});
    bus.load_grant_i = 1'b1;
    bus.data_i       = 32'h4433_2211;
    tick();
    bus.load_grant_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    @(negedge clk);
    check("t5_end_valid", 32'(bus.stream_valid_o), 32'd0);
    check("t5_end_request", 32'(bus.load_request_o), 32'd0);

    // Test 6: reset mid-word loses the partial word; next word (n=4) packs from bit 0
    do_reset(1'b0, 2'd3);
    beat(8'hAA, 8'h00, 1'b1, 1'b0);
    beat(8'hBB, 8'h00, 1'b1, 1'b0);
    do_reset(1'b0, 2'd2);
    @(negedge clk);
    check("t6_no_partial_store", 32'(bus.store_o), 32'd0);
    store_q.push_back('{32'h8765_4321, 1'b0});
    for (int k = 0; k < 8; k++) beat({4'hF, 4'(k + 1)}, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_store", 32'(bus.store_o), 32'd1);
    tick();

    @(negedge clk);
    check("store_queue_drained", 32'(store_q.size()), 32'd0);
    check("stream_queue_drained", 32'(stream_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
